msu_fill: RTL and testbench
===========================

MSU_FILL -- requirements
Module: msu_fill

Interface
REQ-001 clkin  in  1  single clock; all logic on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 fill_data  in  8  byte from MCU stream.
REQ-004 fill_valid  in  1  one-cycle strobe; fill_data is valid.
REQ-005 fill_ready  out  1  high when a byte is accepted this cycle.
REQ-006 seek_addr  in  14  new buffer write/read origin.
REQ-007 seek_we  in  1  one-cycle strobe; flush buffer to seek_addr.
REQ-008 rd_addr  in  14  current MSU data read pointer, from the data-port consumer.
REQ-009 pgm_address  out  14  buffer RAM write address.
REQ-010 pgm_data  out  8  buffer RAM write data.
REQ-011 pgm_we  out  1  buffer RAM write enable, active-low.
REQ-012 fill_level  out  14  bytes written but not yet read.
REQ-013 buf_full  out  1  fill_level == 16383.
REQ-014 half_req  out  1  one-cycle pulse; the read pointer left a half.
REQ-015 half_sel  out  1  index of the freed half, valid with half_req.
REQ-016 overrun  out  1  sticky; a byte was dropped.
REQ-017 err_clr  in  1  one-cycle strobe; clears overrun.

Function
REQ-018 The buffer SHALL be a 16384-byte ring; wr_ptr is 14 bits, and all pointer arithmetic SHALL be modulo 16384.
REQ-019 fill_level SHALL equal (wr_ptr - rd_addr) mod 16384; one slot SHALL stay reserved, so buf_full is asserted at 16383.
REQ-020 The write FSM SHALL have three states.
- IDLE: fill_ready = ~buf_full. On fill_valid & fill_ready, latch fill_data and go to STROBE.
- STROBE: pgm_we = 0 for exactly one cycle, with pgm_address = wr_ptr and pgm_data = the latched byte; then go to ADV.
- ADV: pgm_we = 1; wr_ptr increments by 1; then go to IDLE.
REQ-021 Latency: a byte sampled at edge N SHALL drive pgm_we low during cycle N+1; wr_ptr SHALL update at edge N+2; throughput is one byte per 3 cycles.
REQ-022 pgm_address and pgm_data SHALL stay stable while pgm_we is low and through the following cycle.
REQ-023 fill_valid while fill_ready is low (busy or full) SHALL drop the byte and set overrun; wr_ptr is unchanged.
REQ-024 seek_we SHALL set wr_ptr to seek_addr and return the FSM to IDLE from any state; pgm_we goes high in the next cycle.
REQ-025 seek_we SHALL take priority over fill_valid in the same cycle; that byte is dropped without setting overrun.
REQ-026 An in-flight STROBE aborted by seek_we SHALL NOT increment wr_ptr.
REQ-027 The block SHALL register rd_addr[13] each cycle; on a change of that bit without seek_we, it SHALL pulse half_req for one cycle with half_sel = the old bit value.
REQ-028 A change of rd_addr[13] in the cycle of seek_we, or in the cycle after it, SHALL NOT pulse half_req.
REQ-029 err_clr SHALL clear overrun; if a drop occurs in the same cycle, set SHALL win.
REQ-030 All outputs SHALL be registered except fill_ready, buf_full and fill_level.

Reset
REQ-031 While rst is high, and after it: FSM = IDLE, wr_ptr = 0, pgm_we = 1, pgm_address = 0, pgm_data = 0, half_req = 0, half_sel = 0, overrun = 0, and the rd_addr[13] register = 0.
REQ-032 A reset asserted mid-STROBE SHALL force pgm_we high asynchronously; no partial write state SHALL persist.

Structure
REQ-033 The buffer depth constant (16384), the pointer width (14) and the FSM state encoding SHALL live in the shared msu package.
REQ-034 The half-boundary detector SHALL be a sub-module named msu_half_detect; the ring RAM stays outside this block.

Verification
REQ-035 After reset, fill_valid with 0xA5 → pgm_we low one cycle later, with pgm_address 0x0000 and pgm_data 0xA5; wr_ptr = 1 two edges after sampling.
REQ-036 With rd_addr = 0x0000, write 16383 bytes → buf_full = 1 and fill_ready = 0; the next fill_valid is dropped and overrun = 1; err_clr → overrun = 0.
REQ-037 With wr_ptr = 0x3FFF, write one byte → pgm_address 0x3FFF, then wr_ptr wraps to 0x0000; with rd_addr = 0x3FF0, fill_level = 0x0010.
REQ-038 rd_addr steps 0x1FFF→0x2000 → half_req pulse with half_sel = 0; rd_addr steps 0x3FFF→0x0000 → half_req pulse with half_sel = 1.
REQ-039 seek_we with 0x1234 in the same cycle as fill_valid → wr_ptr = 0x1234, no RAM write, overrun unchanged; seek_we during STROBE → wr_ptr = seek_addr, no increment.

Source files
------------

// File: rtl/msu_pkg.sv
// -----------------------------------------------------------------------------
// msu_pkg
// Shared constants and types for the MSU streaming buffer fill path.
//   MSU_DEPTH      : ring buffer depth in bytes (power of two).
//   MSU_PTR_W      : pointer width; all pointer maths wraps at MSU_DEPTH.
//   MSU_FULL_LEVEL : fill level at which the writer stops. One slot stays
//                    unused so that wr_ptr == rd_addr always means empty.
//   fill_state_e   : write FSM state encoding.
// -----------------------------------------------------------------------------
package msu_pkg;

    localparam int unsigned MSU_DEPTH = 16384;
    localparam int unsigned MSU_PTR_W = 14;

    typedef logic [MSU_PTR_W-1:0] msu_ptr_t;

    localparam msu_ptr_t MSU_FULL_LEVEL = msu_ptr_t'(MSU_DEPTH - 1);

    typedef enum logic [1:0] {
        FILL_IDLE   = 2'd0,
        FILL_STROBE = 2'd1,
        FILL_ADV    = 2'd2
    } fill_state_e;

    // Occupied bytes between writer and reader. The subtraction wraps
    // naturally in MSU_PTR_W bits, which is exactly mod MSU_DEPTH.
    function automatic msu_ptr_t ptr_diff(input msu_ptr_t wr, input msu_ptr_t rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/msu_half_detect.sv
// -----------------------------------------------------------------------------
// msu_half_detect
// Watches the top bit of the consumer read pointer and flags when the reader
// crosses from one half of the ring into the other, so the MCU can refill the
// half that was just vacated.
//
// Ports
//   clkin    in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   rd_msb   in   rd_addr[13] from the data-port consumer
//   seek_we  in   seek strobe; a seek repositions the reader, so any bit
//                 change around it is not a real half crossing
//   half_req out  one-cycle pulse on a half crossing (registered)
//   half_sel out  half that was just left (registered, held between pulses)
// -----------------------------------------------------------------------------
module msu_half_detect (
    input  logic clkin,
    input  logic rst,
    input  logic rd_msb,
    input  logic seek_we,
    output logic half_req,
    output logic half_sel
);

    logic msb_q;
    logic seek_q;
    logic crossed;

    // The pointer may jump in the seek cycle itself or settle one cycle later
    // when the consumer reloads it, so both cycles are masked.
    assign crossed = (rd_msb != msb_q) && !seek_we && !seek_q;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            msb_q    <= 1'b0;
            seek_q   <= 1'b0;
            half_req <= 1'b0;
            half_sel <= 1'b0;
        end else begin
            msb_q    <= rd_msb;
            seek_q   <= seek_we;
            half_req <= crossed;
            if (crossed) begin
                half_sel <= msb_q;
            end
        end
    end

endmodule

// File: rtl/msu_fill.sv
// -----------------------------------------------------------------------------
// msu_fill
// Write side of the MSU streaming ring buffer. Bytes arriving from the MCU
// stream are written into an external 16 KiB ring RAM with a three-cycle
// write sequence; the block tracks the write pointer, reports fill level,
// flags dropped bytes and requests refills when the reader changes halves.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   FILL_IDLE   | waiting for a byte; ready unless the ring is full
//   FILL_STROBE | pgm_we low for one cycle, address/data held
//   FILL_ADV    | write done, advance wr_ptr by one
//
// Ports
//   clkin        in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   fill_data    in   [7:0]  byte from MCU stream
//   fill_valid   in   fill_data valid strobe
//   fill_ready   out  byte is accepted this cycle (combinational)
//   seek_addr    in   [13:0] new write origin
//   seek_we      in   seek strobe; aborts any write in flight
//   rd_addr      in   [13:0] consumer read pointer
//   pgm_address  out  [13:0] RAM write address (registered)
//   pgm_data     out  [7:0]  RAM write data (registered)
//   pgm_we       out  RAM write enable, active-low (registered)
//   fill_level   out  [13:0] bytes written but not yet read (combinational)
//   buf_full     out  ring full, fill_level == 16383 (combinational)
//   half_req     out  one-cycle half-crossing pulse (registered)
//   half_sel     out  half just vacated, valid with half_req (registered)
//   overrun      out  sticky dropped-byte flag (registered)
//   err_clr      in   clears overrun; a same-cycle drop wins
// -----------------------------------------------------------------------------
module msu_fill
    import msu_pkg::*;
(
    input  logic                 clkin,
    input  logic                 rst,
    input  logic [7:0]           fill_data,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    input  logic [MSU_PTR_W-1:0] seek_addr,
    input  logic                 seek_we,
    input  logic [MSU_PTR_W-1:0] rd_addr,
    output logic [MSU_PTR_W-1:0] pgm_address,
    output logic [7:0]           pgm_data,
    output logic                 pgm_we,
    output logic [MSU_PTR_W-1:0] fill_level,
    output logic                 buf_full,
    output logic                 half_req,
    output logic                 half_sel,
    output logic                 overrun,
    input  logic                 err_clr
);

    fill_state_e          state;
    logic [MSU_PTR_W-1:0] wr_ptr;
    logic                 accept;
    logic                 drop;

    assign fill_level = ptr_diff(wr_ptr, rd_addr);
    assign buf_full   = (fill_level == MSU_FULL_LEVEL);
    assign fill_ready = (state == FILL_IDLE) && !buf_full;

    // A seek consumes the cycle: a byte offered alongside it is discarded
    // silently because the stream is being restarted anyway.
    assign accept = fill_valid && fill_ready && !seek_we;
    assign drop   = fill_valid && !fill_ready && !seek_we;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state       <= FILL_IDLE;
            wr_ptr      <= '0;
            pgm_we      <= 1'b1;
            pgm_address <= '0;
            pgm_data    <= '0;
            overrun     <= 1'b0;
        end else begin
            // pgm_we is low only in the single cycle following acceptance.
            pgm_we <= 1'b1;

            if (drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (seek_we) begin
                // Aborting from STROBE or ADV skips the pointer advance.
                wr_ptr <= seek_addr;
                state  <= FILL_IDLE;
            end else begin
                case (state)
                    FILL_IDLE: begin
                        if (accept) begin
                            pgm_address <= wr_ptr;
                            pgm_data    <= fill_data;
                            pgm_we      <= 1'b0;
                            state       <= FILL_STROBE;
                        end
                    end
                    FILL_STROBE: begin
                        state <= FILL_ADV;
                    end
                    FILL_ADV: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= FILL_IDLE;
                    end
                    default: begin
                        state <= FILL_IDLE;
                    end
                endcase
            end
        end
    end

    msu_half_detect u_half_detect (
        .clkin    (clkin),
        .rst      (rst),
        .rd_msb   (rd_addr[MSU_PTR_W-1]),
        .seek_we  (seek_we),
        .half_req (half_req),
        .half_sel (half_sel)
    );

endmodule

// File: tb/tb_msu_fill.sv
// -----------------------------------------------------------------------------
// tb_msu_fill
// Self-checking bench for msu_fill. A behavioural model tracks the write
// pointer as an integer, the write sequence as a count of cycles since the
// last accepted byte, and half crossings as a comparison of successive
// rd_addr[13] samples.
// -----------------------------------------------------------------------------
module tb_msu_fill;

    logic        clkin = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  fill_data  = '0;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [13:0] seek_addr  = '0;
    logic        seek_we    = 1'b0;
    logic [13:0] rd_addr    = '0;
    logic [13:0] pgm_address;
    logic [7:0]  pgm_data;
    logic        pgm_we;
    logic [13:0] fill_level;
    logic        buf_full;
    logic        half_req;
    logic        half_sel;
    logic        overrun;
    logic        err_clr    = 1'b0;

    msu_fill dut (
        .clkin       (clkin),
        .rst         (rst),
        .fill_data   (fill_data),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .seek_addr   (seek_addr),
        .seek_we     (seek_we),
        .rd_addr     (rd_addr),
        .pgm_address (pgm_address),
        .pgm_data    (pgm_data),
        .pgm_we      (pgm_we),
        .fill_level  (fill_level),
        .buf_full    (buf_full),
        .half_req    (half_req),
        .half_sel    (half_sel),
        .overrun     (overrun),
        .err_clr     (err_clr)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_wr;          // write pointer, 0..16383
    int          m_since;       // edges since last accepted byte (>=3: free)
    logic [13:0] m_addr;
    logic [7:0]  m_data;
    bit          m_we_low;
    bit          m_over;
    bit          m_hreq;
    bit          m_hsel;
    bit          m_last_bit;    // rd_addr[13] seen at the previous edge
    bit          m_last_seek;   // seek_we seen at the previous edge
    logic [13:0] cur_rd = '0;

    task automatic model_reset();
        m_wr        = 0;
        m_since     = 3;
        m_addr      = '0;
        m_data      = '0;
        m_we_low    = 0;
        m_over      = 0;
        m_hreq      = 0;
        m_hsel      = 0;
        m_last_bit  = 0;
        m_last_seek = 0;
    endtask

    // One clock cycle: apply inputs, check combinational outputs, advance the
    // model across the edge, then check registered outputs. Entered and left
    // at a falling edge.
    task automatic cycle(input bit fv, input logic [7:0] fd, input bit sw,
                         input logic [13:0] sa, input logic [13:0] rd, input bit ec);
        int lvl;
        bit full, ready, accept, drop, b;
        fill_valid = fv;
        fill_data  = fd;
        seek_we    = sw;
        seek_addr  = sa;
        rd_addr    = rd;
        err_clr    = ec;
        cur_rd     = rd;
        #1;
        lvl   = (m_wr - int'(rd) + 16384) % 16384;
        full  = (lvl == 16383);
        ready = (m_since >= 3) && !full;
        check_val("fill_level", fill_level, lvl);
        check_val("buf_full", buf_full, full);
        check_val("fill_ready", fill_ready, ready);

        accept = fv && !sw && ready;
        drop   = fv && !sw && !ready;
        if (sw) begin
            m_wr    = int'(sa);
            m_since = 3;
        end else if (accept) begin
            m_addr  = 14'(m_wr);
            m_data  = fd;
            m_since = 1;
        end else begin
            if (m_since == 2) m_wr = (m_wr + 1) % 16384;
            if (m_since < 3) m_since++;
        end
        m_we_low = accept;
        m_over   = drop ? 1'b1 : (ec ? 1'b0 : m_over);
        b        = rd[13];
        m_hreq   = (b != m_last_bit) && !sw && !m_last_seek;
        if (m_hreq) m_hsel = m_last_bit;
        m_last_bit  = b;
        m_last_seek = sw;

        @(posedge clkin);
        #1;
        check_val("pgm_we", pgm_we, !m_we_low);
        check_val("pgm_address", pgm_address, m_addr);
        check_val("pgm_data", pgm_data, m_data);
        check_val("overrun", overrun, m_over);
        check_val("half_req", half_req, m_hreq);
        check_val("half_sel", half_sel, m_hsel);
        @(negedge clkin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 14'h0, cur_rd, 0);
    endtask

    task automatic write_byte(input logic [7:0] d);
        cycle(1, d, 0, 14'h0, cur_rd, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clkin);
        @(posedge clkin);
        #1;
        check_val("rst_pgm_we", pgm_we, 1);
        check_val("rst_pgm_address", pgm_address, 0);
        check_val("rst_pgm_data", pgm_data, 0);
        check_val("rst_half_req", half_req, 0);
        check_val("rst_half_sel", half_sel, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_fill_level", fill_level, 0);
        check_val("rst_fill_ready", fill_ready, 1);
        @(negedge clkin);
        rst = 1'b0;

        // First byte after reset lands at address 0, pointer advances 2 edges later.
        write_byte(8'hA5);
        check_val("a5_pgm_we", pgm_we, 0);
        check_val("a5_pgm_address", pgm_address, 14'h0000);
        check_val("a5_pgm_data", pgm_data, 8'hA5);
        idle(1);
        check_val("a5_we_release", pgm_we, 1);
        check_val("a5_level_before_adv", fill_level, 0);
        idle(1);
        check_val("a5_wr_ptr", fill_level, 1);

        // Fill the ring from 0 with the reader parked at 0.
        cycle(0, 8'h00, 1, 14'h0000, 14'h0000, 0);
        for (int i = 0; i < 16383; i++) begin
            write_byte(8'($urandom));
            idle(2);
        end
        check_val("full_level", fill_level, 16383);
        check_val("full_buf_full", buf_full, 1);
        check_val("full_fill_ready", fill_ready, 0);
        write_byte(8'h77);
        check_val("full_drop_we", pgm_we, 1);
        check_val("full_overrun", overrun, 1);
        cycle(0, 8'h00, 0, 14'h0, cur_rd, 1);
        check_val("err_clr_overrun", overrun, 0);

        // Write at the top of the ring and wrap.
        cycle(0, 8'h00, 1, 14'h3FFF, 14'h3FF0, 0);
        write_byte(8'h5A);
        check_val("wrap_pgm_address", pgm_address, 14'h3FFF);
        idle(2);
        check_val("wrap_fill_level", fill_level, 14'h0010);

        // Half crossings.
        cycle(0, 8'h00, 0, 14'h0, 14'h1FFF, 0);
        idle(2);
        cycle(0, 8'h00, 0, 14'h0, 14'h2000, 0);
        check_val("half_lo_req", half_req, 1);
        check_val("half_lo_sel", half_sel, 0);
        idle(1);
        check_val("half_lo_pulse_end", half_req, 0);
        cycle(0, 8'h00, 0, 14'h0, 14'h3FFF, 0);
        idle(2);
        cycle(0, 8'h00, 0, 14'h0, 14'h0000, 0);
        check_val("half_hi_req", half_req, 1);
        check_val("half_hi_sel", half_sel, 1);
        // Crossings in the seek cycle and the cycle after are masked.
        cycle(0, 8'h00, 1, 14'h0000, 14'h2000, 0);
        check_val("seek_mask0", half_req, 0);
        cycle(0, 8'h00, 0, 14'h0, 14'h0000, 0);
        check_val("seek_mask1", half_req, 0);
        idle(2);

        // Seek alongside fill_valid: seek wins, byte dropped quietly.
        cycle(1, 8'hC3, 1, 14'h1234, 14'h1230, 0);
        check_val("seek_fv_we", pgm_we, 1);
        check_val("seek_fv_overrun", overrun, 0);
        check_val("seek_fv_level", fill_level, 4);
        idle(2);
        // Seek during STROBE aborts without advancing.
        write_byte(8'h3C);
        cycle(0, 8'h00, 1, 14'h0100, 14'h0100, 0);
        check_val("seek_strobe_we", pgm_we, 1);
        idle(3);
        check_val("seek_strobe_level", fill_level, 0);

        // Asynchronous reset in the middle of a strobe.
        write_byte(8'h99);
        check_val("pre_rst_we", pgm_we, 0);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_we", pgm_we, 1);
        check_val("async_rst_addr", pgm_address, 0);
        check_val("async_rst_data", pgm_data, 0);
        fill_valid = 0; seek_we = 0; err_clr = 0; rd_addr = '0; cur_rd = '0;
        @(posedge clkin);
        @(negedge clkin);
        rst = 1'b0;
        model_reset();
        idle(3);
        check_val("async_rst_level", fill_level, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [13:0] rd;
            int r;
            r  = $urandom_range(0, 99);
            rd = cur_rd;
            if (r < 40) rd = cur_rd + 14'd1;
            else if (r < 44) rd = 14'($urandom);
            else if (r < 48) rd = cur_rd + 14'h1000;
            cycle($urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 15) == 0, 14'($urandom), rd,
                  $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
